// File: rtl/pulse_stretcher.sv
// Pulse stretcher: synchronizes an asynchronous trigger and emits a clean pulse with
// programmable delay and width. Optional retriggering in ACTIVE under `PS_RETRIGGER_EN.
module pulse_stretcher #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pulse_reg,
    input  logic [15:0] config_reg,
    output logic        pulse_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_level;
    logic                   edge_q;
    logic                   trigger;

    logic [7:0] cfg_delay, cfg_width;
    logic [7:0] delay_lat, delay_lat_next;
    logic [7:0] width_lat, width_lat_next;
    logic [7:0] delay_cnt, delay_cnt_next;
    logic [7:0] width_cnt, width_cnt_next;
    logic       pulse_next;

    assign cfg_width = config_reg[7:0];
    assign cfg_delay = config_reg[15:8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_reg};
            edge_q <= sync_level;
        end
    end

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign trigger    = sync_level & ~edge_q;

    // Counters start at 1 on entry so an equality compare against the latched value
    // ends the phase after exactly that many cycles; the compare also stops them at 255.
    always_comb begin
        state_next     = state;
        delay_lat_next = delay_lat;
        width_lat_next = width_lat;
        delay_cnt_next = delay_cnt;
        width_cnt_next = width_cnt;
        pulse_next     = 1'b0;

        case (state)
            IDLE: begin
                if (trigger) begin
                    delay_lat_next = cfg_delay;
                    width_lat_next = cfg_width;
                    if (cfg_width != 8'd0) begin
                        if (cfg_delay == 8'd0) begin
                            state_next     = ACTIVE;
                            width_cnt_next = 8'd1;
                            pulse_next     = 1'b1;
                        end else begin
                            state_next     = DELAY;
                            delay_cnt_next = 8'd1;
                        end
                    end
                end
            end

            DELAY: begin
                if (delay_cnt == delay_lat) begin
                    state_next     = ACTIVE;
                    width_cnt_next = 8'd1;
                    pulse_next     = 1'b1;
                end else begin
                    delay_cnt_next = delay_cnt + 8'd1;
                end
            end

            ACTIVE: begin
                pulse_next = 1'b1;
                if (width_cnt == width_lat) begin
                    state_next = IDLE;
                    pulse_next = 1'b0;
`ifdef PS_RETRIGGER_EN
                end else if (trigger && (cfg_width != 8'd0)) begin
                    delay_lat_next = cfg_delay;
                    width_lat_next = cfg_width;
                    width_cnt_next = 8'd1;
`endif
                end else begin
                    width_cnt_next = width_cnt + 8'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            delay_lat <= 8'd0;
            width_lat <= 8'd0;
            delay_cnt <= 8'd0;
            width_cnt <= 8'd0;
            pulse_out <= 1'b0;
        end else begin
            state     <= state_next;
            delay_lat <= delay_lat_next;
            width_lat <= width_lat_next;
            delay_cnt <= delay_cnt_next;
            width_cnt <= width_cnt_next;
            pulse_out <= pulse_next;
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: timestamp-based reference model plus directed
// pulse measurements and randomized stimulus.
module tb_pulse_stretcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pulse_reg = 1'b0;
    logic [15:0] config_reg = 16'h0000;
    logic        pulse_out;

    int checks = 0;
    int failures = 0;

    pulse_stretcher #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .pulse_reg  (pulse_reg),
        .config_reg (config_reg),
        .pulse_out  (pulse_out)
    );

    always #20 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, required %0d at %0t", name, actual, required, $time);
        end
    endtask

    // Reference model: the output is described by absolute edge numbers of rise and fall.
    // A trigger is seen at edge n when the input was sampled high at n-2 and low at n-3.
    int edge_n, rise_edge, fall_edge, idle_from;
    bit samp1, samp2, samp3;
    bit expect_out;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_n = 0; rise_edge = -1; fall_edge = -1; idle_from = 0;
            samp1 = 0; samp2 = 0; samp3 = 0;
            expect_out = 0;
            #1;
            check_output("reset_out", int'(pulse_out), 0);
        end else begin
            edge_n++;
            if (samp2 && !samp3) begin
                if (edge_n >= idle_from) begin
                    if (config_reg[7:0] != 8'd0) begin
                        rise_edge = edge_n + int'(config_reg[15:8]);
                        fall_edge = rise_edge + int'(config_reg[7:0]);
                        idle_from = fall_edge + 1;
                    end
                end
`ifdef PS_RETRIGGER_EN
                else if (edge_n > rise_edge && edge_n < fall_edge && config_reg[7:0] != 8'd0) begin
                    fall_edge = edge_n + int'(config_reg[7:0]);
                    idle_from = fall_edge + 1;
                end
`endif
            end
            samp3 = samp2; samp2 = samp1; samp1 = pulse_reg;
            expect_out = (edge_n >= rise_edge) && (edge_n < fall_edge);
            #1;
            check_output("model_out", int'(pulse_out), int'(expect_out));
        end
    end

    // Launches a 50 ns trigger 5 ns after a falling edge and measures the output pulse
    // relative to E0 (index 0 = first rising edge sampling the trigger high).
    task automatic apply_stimulus(input string name, input logic [15:0] cfg,
                                  input logic [15:0] cfg_mid, input int mid_cycle,
                                  input int second_cycle, input int exp_rise,
                                  input int exp_len, input int limit);
        int rise_idx;
        int len;
        rise_idx = -1;
        len = 0;
        @(negedge clk);
        config_reg = cfg;
        fork
            begin #5 pulse_reg = 1'b1; #50 pulse_reg = 1'b0; end
            begin if (mid_cycle >= 0) begin #(mid_cycle * 40 + 10) config_reg = cfg_mid; end end
            begin if (second_cycle >= 0) begin #(second_cycle * 40 + 5) pulse_reg = 1'b1; #50 pulse_reg = 1'b0; end end
        join_none
        for (int idx = 0; idx < limit; idx++) begin
            @(posedge clk);
            #1;
            if (pulse_out) begin
                if (rise_idx < 0) rise_idx = idx;
                len++;
            end else if (rise_idx >= 0) begin
                break;
            end
        end
        check_output({name, "_rise"}, rise_idx, exp_rise);
        check_output({name, "_len"}, len, exp_len);
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_mid_pulse();
        int rise_idx;
        rise_idx = -1;
        @(negedge clk);
        config_reg = 16'h0008;
        fork
            begin #5 pulse_reg = 1'b1; #50 pulse_reg = 1'b0; end
        join_none
        for (int idx = 0; idx < 20 && rise_idx < 0; idx++) begin
            @(posedge clk);
            #1;
            if (pulse_out) rise_idx = idx;
        end
        check_output("rstmid_rise", rise_idx, 2);
        repeat (2) @(posedge clk);
        #11;
        check_output("rstmid_before", int'(pulse_out), 1);
        rst = 1'b0;
        #1;
        check_output("rstmid_drop", int'(pulse_out), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int idx = 0; idx < 12; idx++) begin
            @(posedge clk);
            #1;
            if (pulse_out) rise_idx = 100;
        end
        check_output("rstmid_no_restart", rise_idx, 2);
    endtask

    initial begin
        int highs;
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #9 pulse_reg = ~pulse_reg;
            check_output("rst_hold_out", int'(pulse_out), 0);
        end
        pulse_reg = 1'b0;
        #5 rst = 1'b1;
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (pulse_out) highs++;
        end
        check_output("rst_release_quiet", highs, 0);

        apply_stimulus("w7",    16'h0007, 16'h0007, -1, -1, 2, 7, 40);
        apply_stimulus("w8cfg", 16'h0008, 16'h0302,  5, -1, 2, 8, 40);
        apply_stimulus("d2w1",  16'h0201, 16'h0201, -1, -1, 4, 1, 40);
`ifdef PS_RETRIGGER_EN
        apply_stimulus("retrig", 16'h0008, 16'h0008, -1, 4, 2, 12, 40);
`else
        apply_stimulus("retrig", 16'h0008, 16'h0008, -1, 4, 2, 8, 40);
`endif
        apply_stimulus("w0",    16'h0300, 16'h0300, -1, -1, -1, 0, 20);
        apply_stimulus("w255",  16'h03FF, 16'h03FF, -1, -1, 5, 255, 600);
        apply_stimulus("d255",  16'hFF01, 16'hFF01, -1, -1, 257, 1, 600);
        reset_mid_pulse();

        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            pulse_reg = ($urandom_range(0, 99) < 25);
            if ($urandom_range(0, 29) == 0)
                config_reg = {8'($urandom_range(0, 6)), 8'($urandom_range(0, 12))};
            if ($urandom_range(0, 199) == 0) begin
                #10 rst = 1'b0;
                #15 rst = 1'b1;
            end
        end
        pulse_reg = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
